// File: rtl/exu_div_pkg.sv
// Shared constants and helpers for the iterative RV32M divider (exu_div).
package exu_div_pkg;

    localparam int unsigned RegDataWidth = 32;
    localparam int unsigned RegAddrWidth = 5;

    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;
    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;

    localparam logic [2:0] InstDiv  = 3'b100;
    localparam logic [2:0] InstDivu = 3'b101;
    localparam logic [2:0] InstRem  = 3'b110;
    localparam logic [2:0] InstRemu = 3'b111;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StCalc = 2'b01,
        StEnd  = 2'b10
    } div_state_e;

    // Architectural result for divide-by-zero and signed overflow.
    function automatic logic [RegDataWidth-1:0] special_result(
        input logic                    is_rem,
        input logic                    div_zero,
        input logic [RegDataWidth-1:0] dividend
    );
        if (div_zero) begin
            return is_rem ? dividend : {RegDataWidth{1'b1}};
        end
        return is_rem ? '0 : {1'b1, {(RegDataWidth-1){1'b0}}};
    endfunction

endpackage

// File: rtl/exu_div.sv
// Radix-2 restoring divider, 32 iterations per operation, RV32M special cases.
// Define DIV_FAST_SPECIAL_EN to resolve divide-by-zero / signed overflow straight from IDLE.
module exu_div
    import exu_div_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic [RegDataWidth-1:0] dividend_i,
    input  logic [RegDataWidth-1:0] divisor_i,
    input  logic [2:0]              op_i,
    input  logic [RegAddrWidth-1:0] reg_waddr_i,
    output logic                    busy_o,
    output logic                    ready_o,
    output logic [RegDataWidth-1:0] result_o,
    output logic [RegAddrWidth-1:0] reg_waddr_o
);

    div_state_e              state_q, state_d;
    logic [5:0]              cnt_q, cnt_d;
    logic [RegDataWidth:0]   rem_q, rem_d;
    logic [RegDataWidth-1:0] quo_q, quo_d;
    logic [RegDataWidth-1:0] divisor_q, divisor_d;
    logic [RegDataWidth-1:0] dividend_q, dividend_d;
    logic                    is_rem_q, is_rem_d;
    logic                    q_neg_q, q_neg_d;
    logic                    r_neg_q, r_neg_d;
    logic                    div_zero_q, div_zero_d;
    logic                    ovf_q, ovf_d;
    logic [RegAddrWidth-1:0] waddr_q, waddr_d;
    logic                    busy_q, busy_d;
    logic                    ready_q, ready_d;
    logic [RegDataWidth-1:0] result_q, result_d;

    logic                    is_unsigned, a_neg, b_neg, div_zero_in, ovf_in;
    logic [RegDataWidth-1:0] a_abs, b_abs;
    logic [RegDataWidth:0]   rem_shift, diff, rem_nxt;
    logic                    sub_ok;
    logic [RegDataWidth-1:0] quo_nxt, q_fix, r_fix, final_res;
    logic                    unused_op;

    assign unused_op = op_i[2];

    always_comb begin
        is_unsigned = op_i[0];
        a_neg       = !is_unsigned && dividend_i[RegDataWidth-1];
        b_neg       = !is_unsigned && divisor_i[RegDataWidth-1];
        a_abs       = a_neg ? (~dividend_i + 32'd1) : dividend_i;
        b_abs       = b_neg ? (~divisor_i + 32'd1) : divisor_i;
        div_zero_in = (divisor_i == '0);
        ovf_in      = !is_unsigned && (dividend_i == 32'h8000_0000) &&
                      (divisor_i == 32'hFFFF_FFFF);

        // One shift-subtract step on the {remainder, quotient} pair.
        rem_shift = {rem_q[RegDataWidth-1:0], quo_q[RegDataWidth-1]};
        diff      = rem_shift - {1'b0, divisor_q};
        sub_ok    = !diff[RegDataWidth];
        rem_nxt   = sub_ok ? diff : rem_shift;
        quo_nxt   = {quo_q[RegDataWidth-2:0], sub_ok};

        q_fix     = q_neg_q ? (~quo_nxt + 32'd1) : quo_nxt;
        r_fix     = r_neg_q ? (~rem_nxt[RegDataWidth-1:0] + 32'd1) : rem_nxt[RegDataWidth-1:0];
        final_res = is_rem_q ? r_fix : q_fix;
        if (div_zero_q || ovf_q) begin
            final_res = special_result(is_rem_q, div_zero_q, dividend_q);
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        divisor_d  = divisor_q;
        dividend_d = dividend_q;
        is_rem_d   = is_rem_q;
        q_neg_d    = q_neg_q;
        r_neg_d    = r_neg_q;
        div_zero_d = div_zero_q;
        ovf_d      = ovf_q;
        waddr_d    = waddr_q;
        ready_d    = DivResultNotReady;
        result_d   = '0;

        unique case (state_q)
            StIdle: begin
                if (start_i == DivStart) begin
                    cnt_d      = '0;
                    rem_d      = '0;
                    quo_d      = a_abs;
                    divisor_d  = b_abs;
                    dividend_d = dividend_i;
                    is_rem_d   = op_i[1];
                    q_neg_d    = a_neg ^ b_neg;
                    r_neg_d    = a_neg;
                    div_zero_d = div_zero_in;
                    ovf_d      = ovf_in;
                    waddr_d    = reg_waddr_i;
                    state_d    = StCalc;
`ifdef DIV_FAST_SPECIAL_EN
                    if (div_zero_in || ovf_in) begin
                        state_d  = StEnd;
                        ready_d  = DivResultReady;
                        result_d = special_result(op_i[1], div_zero_in, dividend_i);
                    end
`endif
                end
            end
            StCalc: begin
                if (start_i == DivStop) begin
                    state_d = StIdle;
                end else begin
                    rem_d = rem_nxt;
                    quo_d = quo_nxt;
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == 6'd31) begin
                        state_d  = StEnd;
                        ready_d  = DivResultReady;
                        result_d = final_res;
                    end
                end
            end
            StEnd: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d == StCalc);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            divisor_q  <= '0;
            dividend_q <= '0;
            is_rem_q   <= 1'b0;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            div_zero_q <= 1'b0;
            ovf_q      <= 1'b0;
            waddr_q    <= '0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            divisor_q  <= divisor_d;
            dividend_q <= dividend_d;
            is_rem_q   <= is_rem_d;
            q_neg_q    <= q_neg_d;
            r_neg_q    <= r_neg_d;
            div_zero_q <= div_zero_d;
            ovf_q      <= ovf_d;
            waddr_q    <= waddr_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
            result_q   <= result_d;
        end
    end

    assign busy_o      = busy_q;
    assign ready_o     = ready_q;
    assign result_o    = result_q;
    assign reg_waddr_o = waddr_q;

endmodule

// File: tb/tb_exu_div.sv
// Self-checking bench for exu_div: vector table, scoreboard queue, abort/reset/operand-change cases.
module tb_exu_div;
    import exu_div_pkg::*;

`ifdef DIV_FAST_SPECIAL_EN
    localparam bit Fast = 1'b1;
`else
    localparam bit Fast = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [31:0] dividend_i, divisor_i;
    logic [2:0]  op_i;
    logic [4:0]  reg_waddr_i;
    logic        busy_o, ready_o;
    logic [31:0] result_o;
    logic [4:0]  reg_waddr_o;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  tag;
        logic [31:0] exp;
        bit          special;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
        int          lat;
        int          busy;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[13];

    exu_div dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .dividend_i  (dividend_i),
        .divisor_i   (divisor_i),
        .op_i        (op_i),
        .reg_waddr_i (reg_waddr_i),
        .busy_o      (busy_o),
        .ready_o     (ready_o),
        .result_o    (result_o),
        .reg_waddr_o (reg_waddr_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Reference model built from the language's own division operators.
    function automatic logic [31:0] ref_div(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return op[1] ? 32'h0 : 32'h8000_0000;
        if (op[0]) return op[1] ? (a % b) : (a / b);
        return op[1] ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
    endfunction

    function automatic bit is_special(input logic [2:0] op, input logic [31:0] a,
                                      input logic [31:0] b);
        return (b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] tag, input logic [31:0] exp,
                          input bit special, input bit mangle);
        exp_t e;
        int k, busy_n;
        bit got, both, nz;
        logic [31:0] res;
        logic [4:0] wa;
        e.res  = exp;
        e.tag  = tag;
        e.lat  = (special && Fast) ? 1 : 33;
        e.busy = (special && Fast) ? 0 : 32;
        sb.push_back(e);
        @(negedge clk);
        start_i = 1'b1; op_i = op; dividend_i = a; divisor_i = b; reg_waddr_i = tag;
        k = 0; busy_n = 0; got = 0; both = 0; nz = 0; res = '0; wa = '0;
        while (!got && k < 40) begin
            @(negedge clk);
            k++;
            if (busy_o) busy_n++;
            if (busy_o && ready_o) both = 1;
            if (!ready_o && result_o != 0) nz = 1;
            if (mangle && k == 5) begin
                dividend_i = $urandom; divisor_i = $urandom; reg_waddr_i = ~tag; op_i = ~op;
            end
            if (ready_o) begin
                got = 1; res = result_o; wa = reg_waddr_o;
            end
        end
        start_i = 1'b0;
        e = sb.pop_front();
        check({name, "_ready_seen"}, 32'(got), 32'd1);
        if (got) begin
            check({name, "_latency"}, k, e.lat);
            check({name, "_result"}, res, e.res);
            check({name, "_waddr"}, 32'(wa), 32'(e.tag));
            check({name, "_busy_cycles"}, busy_n, e.busy);
            check({name, "_busy_and_ready"}, 32'(both), 32'd0);
            check({name, "_result_zero_idle"}, 32'(nz), 32'd0);
            @(negedge clk);
            check({name, "_ready_pulse_len"}, 32'(ready_o), 32'd0);
        end
    endtask

    // Watch n cycles and count stray ready pulses.
    task automatic no_ready(input string name, input int n);
        int seen;
        seen = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (ready_o) seen++;
        end
        check({name, "_no_ready"}, seen, 0);
    endtask

    initial begin
        logic [1:0]  r2;
        logic [2:0]  rop;
        logic [31:0] ra, rb;

        vecs[0]  = '{InstDivu, 32'd100,        32'd7,          5'd5,  32'd14,        1'b0};
        vecs[1]  = '{InstRem,  32'hFFFF_FFF9,  32'd2,          5'd1,  32'hFFFF_FFFF, 1'b0};
        vecs[2]  = '{InstDiv,  32'hFFFF_FFF9,  32'd2,          5'd2,  32'hFFFF_FFFD, 1'b0};
        vecs[3]  = '{InstRemu, 32'hFFFF_FFFF,  32'd16,         5'd3,  32'd15,        1'b0};
        vecs[4]  = '{InstDiv,  32'h8000_0000,  32'hFFFF_FFFF,  5'd4,  32'h8000_0000, 1'b1};
        vecs[5]  = '{InstRem,  32'h8000_0000,  32'hFFFF_FFFF,  5'd6,  32'h0,         1'b1};
        vecs[6]  = '{InstDivu, 32'd5,          32'd0,          5'd7,  32'hFFFF_FFFF, 1'b1};
        vecs[7]  = '{InstRemu, 32'd5,          32'd0,          5'd8,  32'd5,         1'b1};
        vecs[8]  = '{InstDiv,  32'd7,          32'd0,          5'd9,  32'hFFFF_FFFF, 1'b1};
        vecs[9]  = '{InstRem,  32'hFFFF_FFFB,  32'd0,          5'd10, 32'hFFFF_FFFB, 1'b1};
        vecs[10] = '{InstDiv,  32'd20,         32'hFFFF_FFFD,  5'd11, 32'hFFFF_FFFA, 1'b0};
        vecs[11] = '{InstRem,  32'd20,         32'hFFFF_FFFD,  5'd12, 32'd2,         1'b0};
        vecs[12] = '{3'b001,   32'd50,         32'd5,          5'd31, 32'd10,        1'b0};

        rst = 1'b1; start_i = 1'b0; dividend_i = '0; divisor_i = '0; op_i = '0; reg_waddr_i = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", 32'(busy_o), 32'd0);
        check("reset_ready", 32'(ready_o), 32'd0);
        check("reset_result", result_o, 32'd0);
        check("reset_waddr", 32'(reg_waddr_o), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag,
                   vecs[i].exp, vecs[i].special, 1'b0);
            @(negedge clk);
        end

        for (int i = 0; i < 12; i++) begin
            r2  = 2'($urandom_range(0, 3));
            rop = {1'b1, r2};
            ra  = $urandom;
            rb  = (i % 3 == 0) ? 32'($urandom_range(1, 20)) : 32'($urandom);
            if (i == 5) rb = 32'd0;
            run_op($sformatf("rnd%0d", i), rop, ra, rb, 5'(i), ref_div(rop, ra, rb),
                   is_special(rop, ra, rb), 1'b0);
            @(negedge clk);
        end

        // Operands wiggle mid-CALC; latched values must win.
        run_op("latched_ops", InstDivu, 32'd1000, 32'd9, 5'd3, 32'd111, 1'b0, 1'b1);
        @(negedge clk);

        // Abort: start_i dropped in cycle N+10.
        @(negedge clk);
        start_i = 1'b1; op_i = InstDivu; dividend_i = 32'd100; divisor_i = 32'd7;
        reg_waddr_i = 5'd5;
        for (int k = 1; k <= 10; k++) @(negedge clk);
        check("abort_busy_before", 32'(busy_o), 32'd1);
        start_i = 1'b0;
        @(negedge clk);
        check("abort_busy_after", 32'(busy_o), 32'd0);
        no_ready("abort", 40);
        run_op("after_abort", InstDivu, 32'd9, 32'd3, 5'd14, 32'd3, 1'b0, 1'b0);
        @(negedge clk);

        // Reset mid-operation at N+20.
        @(negedge clk);
        start_i = 1'b1; op_i = InstDivu; dividend_i = 32'd100; divisor_i = 32'd7;
        reg_waddr_i = 5'd21;
        for (int k = 1; k <= 20; k++) @(negedge clk);
        rst = 1'b1; start_i = 1'b0;
        @(negedge clk);
        check("midrst_busy", 32'(busy_o), 32'd0);
        check("midrst_ready", 32'(ready_o), 32'd0);
        check("midrst_result", result_o, 32'd0);
        check("midrst_waddr", 32'(reg_waddr_o), 32'd0);
        rst = 1'b0;
        no_ready("midrst", 40);
        run_op("after_rst", InstRemu, 32'd100, 32'd7, 5'd17, 32'd2, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/exu_div.md
# exu_div

Iterative radix-2 restoring divider: the responder side of the execute-unit division handshake. It accepts start, operands, op code and destination register from the division control unit, and runs for a fixed number of cycles while signalling busy. It then returns a one-cycle ready pulse carrying the RV32M quotient or remainder and the tagged write address.

## Interface
Parameters: none. Widths come from `defines.v` (`REG_DATA_WIDTH` = 32, `REG_ADDR_WIDTH`).

- clk  input  1  core clock
- rst  input  1  reset; synchronous, active-high
- start_i  input  1  `DivStart`/`DivStop`; must stay high for the whole operation
- dividend_i  input  REG_DATA_WIDTH  rs1 value
- divisor_i  input  REG_DATA_WIDTH  rs2 value
- op_i  input  3  funct3: DIV=100, DIVU=101, REM=110, REMU=111
- reg_waddr_i  input  REG_ADDR_WIDTH  destination register tag
- busy_o  output  1  operation in progress
- ready_o  output  1  `DivResultReady`; one-cycle result-valid pulse
- result_o  output  REG_DATA_WIDTH  quotient or remainder; zero when ready_o is low
- reg_waddr_o  output  REG_ADDR_WIDTH  latched tag; valid with ready_o

## Operation
- States:
  - IDLE: waits for start_i. On start_i=1, latch operands, op and tag, then enter CALC, or END when the special fast path applies.
  - CALC: 32 iterations of shift-subtract.
  - END: present the result, then return to IDLE.
- Op decode: op[0]=1 selects unsigned; op[1]=1 selects remainder; op[2] is ignored.
- Signed ops divide magnitudes. Quotient sign is sign(a) XOR sign(b); remainder sign is sign(a).
- Partial remainder is 33 bits. Each iteration shifts in one dividend bit and subtracts the divisor if the result is non-negative; the quotient bit is 1 when the subtraction succeeds.
- Special results are applied in END in all configurations:
  - Divisor = 0: quotient = 0xFFFFFFFF; remainder = dividend.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): quotient = 0x80000000; remainder = 0.
- Abort: start_i sampled low in CALC returns the block to IDLE with no ready pulse. This covers interrupt preemption by the control unit.
- start_i is ignored in END. A new operation can only be accepted from IDLE.
- Inputs other than start_i are sampled only on acceptance. Later changes have no effect.

## Timing
- Reset: state = IDLE; busy_o=0, ready_o=0, result_o=0, reg_waddr_o=0; all internal registers cleared. Reset in any state takes effect at the next edge and discards any operation in flight.
- Acceptance at edge N (IDLE, start_i=1).
- Normal path:
  - busy_o=1 in cycles N+1..N+32 (CALC).
  - END in cycle N+33: ready_o=1, busy_o=0, result_o and reg_waddr_o valid.
  - IDLE at N+34.
  - Accept-to-ready latency is 33 cycles.
- Fast path (with `DIV_FAST_SPECIAL_EN`): END in cycle N+1. busy_o never rises, and latency is 1 cycle.
- ready_o and busy_o are never high together.
- All outputs are registered.
- The earliest back-to-back acceptance is edge N+34.

## Configuration
- `DIV_FAST_SPECIAL_EN` defined: divide-by-zero and signed overflow are detected in IDLE and jump straight to END. busy_o stays low, and ready follows acceptance by one cycle.
- Not defined: these cases run the full 32 CALC iterations, and the END override produces the same architectural result.
- Results are identical in both configurations; only latency differs.

## Structure
- Constants `DivStart`, `DivStop`, `DivResultReady`, `DivResultNotReady` and `INST_DIV`/`INST_DIVU`/`INST_REM`/`INST_REMU` live in `defines.v`. State encodings (IDLE=2'b00, CALC=2'b01, END=2'b10) are local parameters.
- Single module; no sub-module is needed. A 6-bit iteration counter runs from 0 to 31.

## Test plan
- DIVU 100 / 7 (tag 5) -> ready at N+33 with result 14 and reg_waddr_o 5. busy_o is high for exactly 32 cycles.
- REM -7 / 2 -> 0xFFFFFFFF (-1). DIV -7 / 2 -> 0xFFFFFFFD (-3). REMU 0xFFFFFFFF / 16 -> 15.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. REM of the same operands -> 0. DIVU 5 / 0 -> 0xFFFFFFFF. REMU 5 / 0 -> 5.
  - Check each of these both with and without the macro; latency must be 1 or 33 cycles accordingly.
- Drop start_i at N+10 -> busy_o falls at N+11 and no ready pulse appears. A new DIVU 9 / 3 accepted afterwards -> result 3.
- Assert rst at N+20 -> on the next cycle all outputs are 0 and the state is IDLE, with no ready pulse.
- Change dividend_i and divisor_i during CALC while holding start_i -> result equals the value computed from the latched operands.
